// File: rtl/bram_sp_arbiter_pkg.sv
// Shared types for the single-port BRAM arbiter.
// BRAM_ARB_ROUND_ROBIN_EN selects round-robin over fixed priority.
package bram_arb_pkg;

    localparam int MAX_REQ = 8;

    typedef logic [2:0] req_idx_t;

    function automatic req_idx_t wrap_inc(
        input req_idx_t i,
        input int       n
    );
        return (int'(i) + 1 >= n) ? req_idx_t'(0) : i + 3'd1;
    endfunction

endpackage

// File: rtl/bram_sp_arbiter_if.sv
// Requester, response and BRAM-side signals of the arbiter.
// Option macro of the block: BRAM_ARB_ROUND_ROBIN_EN.
interface bram_sp_arbiter_if #(
    parameter int NUM_REQ = 2,
    parameter int DW      = 32,
    parameter int AW      = 4
);
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [NUM_REQ-1:0]    req_wr;
    logic [NUM_REQ*AW-1:0] req_addr;
    logic [NUM_REQ*DW-1:0] req_wdata;
    logic [NUM_REQ-1:0]    rsp_valid;
    logic [DW-1:0]         rsp_data;
    logic                  ram_wr;
    logic [AW-1:0]         ram_addr;
    logic [DW-1:0]         ram_wdata;
    logic [DW-1:0]         ram_rdata;

    modport master (
        output req_valid, req_wr, req_addr,
        output req_wdata, ram_rdata,
        input  req_ready, rsp_valid, rsp_data,
        input  ram_wr, ram_addr, ram_wdata
    );

    modport slave (
        input  req_valid, req_wr, req_addr,
        input  req_wdata, ram_rdata,
        output req_ready, rsp_valid, rsp_data,
        output ram_wr, ram_addr, ram_wdata
    );

endinterface

// File: rtl/bram_sp_arbiter_rr_arbiter.sv
// One-hot grant from a request vector.
// BRAM_ARB_ROUND_ROBIN_EN: rotating pointer; else lowest index wins.
module rr_arbiter
    import bram_arb_pkg::*;
#(
    parameter int NUM_REQ = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] i_req,
    input  logic               i_adv,
    output logic [NUM_REQ-1:0] o_gnt
);

`ifdef BRAM_ARB_ROUND_ROBIN_EN
    req_idx_t r_ptr;
    req_idx_t w_win;
    logic     w_found;
    int       w_idx;

    // Search starts at the pointer and wraps past the top index.
    always_comb begin
        o_gnt   = '0;
        w_win   = r_ptr;
        w_found = 1'b0;
        w_idx   = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_idx = int'(r_ptr) + k;
            if (w_idx >= NUM_REQ)
                w_idx = w_idx - NUM_REQ;
            if (!w_found && i_req[w_idx]) begin
                w_found      = 1'b1;
                o_gnt[w_idx] = 1'b1;
                w_win        = req_idx_t'(w_idx);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst)
            r_ptr <= '0;
        else if (i_adv)
            r_ptr <= wrap_inc(w_win, NUM_REQ);
    end
`else
    logic w_found;
    wire  w_unused = &{1'b0, clk, rst, i_adv};

    always_comb begin
        o_gnt   = '0;
        w_found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!w_found && i_req[k]) begin
                w_found  = 1'b1;
                o_gnt[k] = 1'b1;
            end
        end
    end
`endif

endmodule

// File: rtl/bram_sp_arbiter.sv
// Shares one read-first single-port BRAM between NUM_REQ requesters.
// Arbitration policy set by BRAM_ARB_ROUND_ROBIN_EN (see rr_arbiter).
module bram_sp_arbiter
    import bram_arb_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int RAM_DATA_WIDTH = 32,
    parameter int RAM_ADDR_WIDTH = 4
) (
    input logic              clk,
    input logic              rst,
    bram_sp_arbiter_if.slave bus
);

    localparam int DW = RAM_DATA_WIDTH;
    localparam int AW = RAM_ADDR_WIDTH;

    logic [NUM_REQ-1:0] w_arb_gnt;
    logic [NUM_REQ-1:0] w_gnt;
    logic               w_xfer;
    logic               w_wr;
    logic [AW-1:0]      w_addr;
    logic [DW-1:0]      w_wdata;
    logic [NUM_REQ-1:0] r_tag;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .clk   (clk),
        .rst   (rst),
        .i_req (bus.req_valid),
        .i_adv (w_xfer),
        .o_gnt (w_arb_gnt)
    );

    assign w_gnt  = rst ? w_arb_gnt : '0;
    assign w_xfer = |w_gnt;

    always_comb begin
        w_wr    = 1'b0;
        w_addr  = '0;
        w_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_gnt[i]) begin
                w_wr    = bus.req_wr[i];
                w_addr  = bus.req_addr[i*AW +: AW];
                w_wdata = bus.req_wdata[i*DW +: DW];
            end
        end
    end

    // Tag remembers who issued the read landing on ram_rdata next cycle.
    always_ff @(posedge clk) begin
        if (!rst)
            r_tag <= '0;
        else
            r_tag <= w_gnt & ~bus.req_wr;
    end

    assign bus.req_ready = w_gnt;
    assign bus.ram_wr    = w_wr;
    assign bus.ram_addr  = w_addr;
    assign bus.ram_wdata = w_wdata;
    // Gated so a reset landing on an in-flight read never pulses.
    assign bus.rsp_valid = rst ? r_tag : '0;
    assign bus.rsp_data  = bus.ram_rdata;

endmodule

// File: tb/tb_bram_sp_arbiter.sv
// Directed bench for bram_sp_arbiter with a read-response scoreboard.
// Expectations follow BRAM_ARB_ROUND_ROBIN_EN when defined.
module tb_bram_sp_arbiter;

`ifdef BRAM_ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    typedef struct {
        logic [1:0]  vld;
        logic [31:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;
    int   n_chk  = 0;
    int   n_fail = 0;

    exp_t        sb[$];
    logic [31:0] shadow[16];
    logic [31:0] mem[16];
    logic [2:0]  b_prev;

    always #5 clk = ~clk;

    bram_sp_arbiter_if #(.NUM_REQ(2), .DW(32), .AW(4)) a_if ();
    bram_sp_arbiter_if #(.NUM_REQ(3), .DW(32), .AW(4)) b_if ();

    bram_sp_arbiter #(
        .NUM_REQ(2), .RAM_DATA_WIDTH(32), .RAM_ADDR_WIDTH(4)
    ) u_a (
        .clk (clk),
        .rst (rst_a),
        .bus (a_if.slave)
    );

    bram_sp_arbiter #(
        .NUM_REQ(3), .RAM_DATA_WIDTH(32), .RAM_ADDR_WIDTH(4)
    ) u_b (
        .clk (clk),
        .rst (rst_b),
        .bus (b_if.slave)
    );

    // Read-first single-port BRAM with registered output.
    always @(posedge clk) begin
        if (a_if.ram_wr)
            mem[a_if.ram_addr] <= a_if.ram_wdata;
        a_if.ram_rdata <= mem[a_if.ram_addr];
    end

    task automatic cycle_a(
        input logic [1:0] exp_rdy,
        input logic       exp_wr,
        input string      tag
    );
        exp_t       e;
        int         idx;
        logic [3:0] ad;
        @(negedge clk);
        n_chk++;
        assert (a_if.req_ready === exp_rdy) else begin
            n_fail++;
            $error("FAIL %s ready obs=%b exp=%b",
                   tag, a_if.req_ready, exp_rdy);
        end
        n_chk++;
        assert (a_if.ram_wr === exp_wr) else begin
            n_fail++;
            $error("FAIL %s ram_wr obs=%b exp=%b",
                   tag, a_if.ram_wr, exp_wr);
        end
        if (sb.size() > 0) begin
            e = sb.pop_front();
            n_chk++;
            assert (a_if.rsp_valid === e.vld) else begin
                n_fail++;
                $error("FAIL %s rsp_valid obs=%b exp=%b",
                       tag, a_if.rsp_valid, e.vld);
            end
            n_chk++;
            assert (a_if.rsp_data === e.data) else begin
                n_fail++;
                $error("FAIL %s rsp_data obs=%h exp=%h",
                       tag, a_if.rsp_data, e.data);
            end
        end else begin
            n_chk++;
            assert (a_if.rsp_valid === 2'b00) else begin
                n_fail++;
                $error("FAIL %s rsp_idle obs=%b exp=00",
                       tag, a_if.rsp_valid);
            end
        end
        if (exp_rdy != 2'b00) begin
            idx = exp_rdy[1] ? 1 : 0;
            ad  = a_if.req_addr[idx*4 +: 4];
            if (a_if.req_wr[idx])
                shadow[ad] = a_if.req_wdata[idx*32 +: 32];
            else
                sb.push_back('{vld: exp_rdy, data: shadow[ad]});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic cycle_b(
        input logic [2:0] exp_rdy,
        input string      tag
    );
        @(negedge clk);
        n_chk++;
        assert (b_if.req_ready === exp_rdy) else begin
            n_fail++;
            $error("FAIL %s ready obs=%b exp=%b",
                   tag, b_if.req_ready, exp_rdy);
        end
        n_chk++;
        assert (b_if.rsp_valid === b_prev) else begin
            n_fail++;
            $error("FAIL %s rsp_valid obs=%b exp=%b",
                   tag, b_if.rsp_valid, b_prev);
        end
        b_prev = exp_rdy;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_a = 1'b0;
        rst_b = 1'b0;
        b_prev = 3'b000;
        a_if.req_valid = '0;
        a_if.req_wr    = '0;
        a_if.req_addr  = '0;
        a_if.req_wdata = '0;
        b_if.req_valid = '0;
        b_if.req_wr    = '0;
        b_if.req_addr  = '0;
        b_if.req_wdata = '0;
        b_if.ram_rdata = '0;
        @(posedge clk);
        #1;

        // 1: reset blocks all grants
        a_if.req_valid = 2'b11;
        for (int i = 0; i < 3; i++)
            cycle_a(2'b00, 1'b0, "reset");

        // 2: write then read back on req0
        rst_a = 1'b1;
        a_if.req_valid = 2'b01;
        a_if.req_wr    = 2'b01;
        a_if.req_addr  = {4'd0, 4'd3};
        a_if.req_wdata = {32'd0, 32'hDEADBEEF};
        cycle_a(2'b01, 1'b1, "wr0");
        a_if.req_wr = 2'b00;
        cycle_a(2'b01, 1'b0, "rd0");
        a_if.req_valid = 2'b00;
        cycle_a(2'b00, 1'b0, "rsp0");

        // preload addr1/addr2 from each requester alone
        a_if.req_valid = 2'b01;
        a_if.req_wr    = 2'b11;
        a_if.req_addr  = {4'd2, 4'd1};
        a_if.req_wdata = {32'h2222_2222, 32'h1111_1111};
        cycle_a(2'b01, 1'b1, "pre1");
        a_if.req_valid = 2'b10;
        cycle_a(2'b10, 1'b1, "pre2");
        a_if.req_valid = 2'b00;
        a_if.req_wr    = 2'b00;
        rst_a = 1'b0;
        cycle_a(2'b00, 1'b0, "rst2");

        // 3/4: both requesters read continuously
        rst_a = 1'b1;
        a_if.req_valid = 2'b11;
        for (int i = 0; i < 6; i++) begin
            if (RR)
                cycle_a(i[0] ? 2'b10 : 2'b01, 1'b0, "both");
            else
                cycle_a(2'b01, 1'b0, "both");
        end
        a_if.req_valid = 2'b00;
        cycle_a(2'b00, 1'b0, "drain");
        cycle_a(2'b00, 1'b0, "idle");

        // 5: reset right after a read is accepted
        a_if.req_valid = 2'b01;
        a_if.req_addr  = {4'd2, 4'd3};
        cycle_a(2'b01, 1'b0, "rd_rst");
        a_if.req_valid = 2'b00;
        rst_a = 1'b0;
        sb.delete();
        cycle_a(2'b00, 1'b0, "rst_fly");
        rst_a = 1'b1;
        cycle_a(2'b00, 1'b0, "post1");
        cycle_a(2'b00, 1'b0, "post2");

        // 6: three requesters, pointer parked at 2
        cycle_b(3'b000, "b_rst");
        rst_b = 1'b1;
        b_if.req_valid = 3'b010;
        cycle_b(3'b010, "b_ptr");
        b_if.req_valid = 3'b101;
        cycle_b(RR ? 3'b100 : 3'b001, "b_g1");
        cycle_b(3'b001, "b_wrap");
        cycle_b(RR ? 3'b100 : 3'b001, "b_g3");
        b_if.req_valid = 3'b000;
        cycle_b(3'b000, "b_end");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
